// File: rtl/pixel_buffer_pkg.sv
// Shared types and helpers for the multi-frame pixel store.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: capture mode encoding, capture FSM state encoding, and a
// constant-evaluable ceil(log2()) used to size derived parameters.
package pixel_buffer_pkg;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_store_ram.sv
// Frame store: NUM_FRAMES x FRAME_WIDTH array, one full-frame write port, one word-select read port.
// Latency: write takes effect at the edge; read data registered, 1 cycle after i_re.
// Backpressure: none; accepts a write and a read every cycle.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata    write a whole frame to physical slot i_waddr
//   i_re/i_rframe/i_rword   read word i_rword of physical slot i_rframe
//   i_rzero                 force the read result to zero (out-of-range access)
//   o_rdata                 registered read word, holds when i_re is low
module frame_store_ram #(
    parameter int FRAME_WIDTH     = 256,
    parameter int NUM_FRAMES      = 8,
    parameter int WORD_WIDTH      = 32,
    parameter int WORDS_PER_FRAME = 8,
    parameter int FIDX_W          = 3,
    parameter int WSEL_W          = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [FIDX_W-1:0]      i_waddr,
    input  logic [FRAME_WIDTH-1:0] i_wdata,
    input  logic                   i_re,
    input  logic                   i_rzero,
    input  logic [FIDX_W-1:0]      i_rframe,
    input  logic [WSEL_W-1:0]      i_rword,
    output logic [WORD_WIDTH-1:0]  o_rdata
);

    localparam int ROW_W = WORDS_PER_FRAME * WORD_WIDTH;

    // Contents are deliberately not reset.
    logic [FRAME_WIDTH-1:0] r_mem [NUM_FRAMES];
    logic [ROW_W-1:0]       w_row;
    logic [WORD_WIDTH-1:0]  w_word;
    logic [WORD_WIDTH-1:0]  r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Zero-extend the frame to a whole number of words so the bits above
    // FRAME_WIDTH in the last word read back as zero.
    always_comb begin
        w_row                  = '0;
        w_row[FRAME_WIDTH-1:0] = r_mem[i_rframe];
        w_word                 = '0;
        for (int w = 0; w < WORDS_PER_FRAME; w++) begin
            if (i_rword == WSEL_W'(w)) begin
                w_word = w_row[w*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // The read samples the array before this edge's write lands, so a
    // same-cycle read of the slot being written returns the old frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : w_word;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/multi_frame_store_core.sv
// Multi-frame capture core: one-shot or ring capture of FRAME_WIDTH-bit frames with an oldest-first word read port.
// Latency: capture writes at the strobe edge; reads return 1 cycle after rd_en.
// Backpressure: none; every frame_valid in CAPTURE is stored, reads accepted every cycle.
//
// Ports:
//   axi_clk, axi_resetn          clock, async active-low reset
//   frame_in, frame_valid        frame data and its one-cycle strobe
//   mode, arm, stop, clear       capture control (mode sampled on arm)
//   busy, done, wrapped          status: capturing, finished, ring overwrote oldest
//   frame_count                  valid frames held, saturating at NUM_FRAMES
//   rd_en, rd_addr               read request, frame_idx*WORDS_PER_FRAME + word_idx
//   rd_data, rd_valid            read response
module multi_frame_store_core
    import pixel_buffer_pkg::*;
#(
    parameter  int FRAME_WIDTH     = 256,
    parameter  int NUM_FRAMES      = 8,
    parameter  int WORD_WIDTH      = 32,
    localparam int WORDS_PER_FRAME = (FRAME_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int RD_ADDR_WIDTH   = clog2(NUM_FRAMES * WORDS_PER_FRAME),
    localparam int CNT_W           = clog2(NUM_FRAMES + 1)
) (
    input  logic                     axi_clk,
    input  logic                     axi_resetn,
    input  logic [FRAME_WIDTH-1:0]   frame_in,
    input  logic                     frame_valid,
    input  logic                     mode,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     wrapped,
    output logic [CNT_W-1:0]         frame_count,
    input  logic                     rd_en,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0]    rd_data,
    output logic                     rd_valid
);

    localparam int FIDX_W    = clog2(NUM_FRAMES);
    localparam int CMP_W     = (RD_ADDR_WIDTH > CNT_W) ? RD_ADDR_WIDTH : CNT_W;
    localparam int TOTAL_WDS = NUM_FRAMES * WORDS_PER_FRAME;

    localparam logic [CNT_W-1:0]         CNT_FULL   = CNT_W'(NUM_FRAMES);
    localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(NUM_FRAMES - 1);
    localparam logic [RD_ADDR_WIDTH-1:0] WPF_A      = RD_ADDR_WIDTH'(WORDS_PER_FRAME);
    localparam logic [RD_ADDR_WIDTH:0]   ADDR_LIMIT = (RD_ADDR_WIDTH + 1)'(TOTAL_WDS);

    // ---------------------------------------------------------------
    // Capture FSM and pointers
    // ---------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_nxt;
    mode_e               r_mode;
    mode_e               w_mode_nxt;
    logic [FIDX_W-1:0]   r_wr_ptr;
    logic [FIDX_W-1:0]   w_wr_ptr_nxt;
    logic [CNT_W-1:0]    r_frame_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_wrapped;
    logic                w_wrapped_nxt;
    logic                w_we;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_valid;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_ONESHOT;
            r_wr_ptr      <= '0;
            r_frame_count <= '0;
            r_wrapped     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mode        <= w_mode_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_frame_count <= w_count_nxt;
            r_wrapped     <= w_wrapped_nxt;
            // Status flags are registered copies of the next state so they
            // line up with r_state without a combinational path to outputs.
            r_busy        <= (w_state_nxt == ST_CAPTURE);
            r_done        <= (w_state_nxt == ST_DONE);
            r_rd_valid    <= rd_en;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_count_nxt   = r_frame_count;
        w_wrapped_nxt = r_wrapped;
        w_we          = 1'b0;

        if (clear) begin
            // Abort wins over everything; the store itself is left alone.
            w_state_nxt   = ST_IDLE;
            w_wr_ptr_nxt  = '0;
            w_count_nxt   = '0;
            w_wrapped_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        w_state_nxt   = ST_CAPTURE;
                        w_mode_nxt    = mode_e'(mode);
                        w_wr_ptr_nxt  = '0;
                        w_count_nxt   = '0;
                        w_wrapped_nxt = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (frame_valid) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        if (r_frame_count == CNT_FULL) begin
                            // Only reachable in ring mode: one-shot leaves
                            // CAPTURE on the write that fills the store.
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_frame_count + 1'b1;
                        end
                        if (r_mode == MODE_ONESHOT && r_frame_count == CNT_LAST) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                    // A coincident strobe has already been written above.
                    if (stop) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Read address mapping: logical (oldest-first) to physical slot
    // ---------------------------------------------------------------
    logic [RD_ADDR_WIDTH-1:0] w_frame_idx;
    logic [RD_ADDR_WIDTH-1:0] w_word_idx;
    logic [FIDX_W-1:0]        w_oldest;
    logic [FIDX_W-1:0]        w_phys_frame;
    logic                     w_rd_zero;

    assign w_frame_idx  = rd_addr / WPF_A;
    assign w_word_idx   = rd_addr % WPF_A;
    // Before the ring wraps, slot 0 holds the oldest frame; afterwards the
    // write pointer points at it. NUM_FRAMES is a power of two, so the
    // modulo is just truncation to FIDX_W bits.
    assign w_oldest     = r_wrapped ? r_wr_ptr : '0;
    assign w_phys_frame = w_oldest + w_frame_idx[FIDX_W-1:0];
    assign w_rd_zero    = ({1'b0, rd_addr} >= ADDR_LIMIT) ||
                          (CMP_W'(w_frame_idx) >= CMP_W'(r_frame_count));

    frame_store_ram #(
        .FRAME_WIDTH     (FRAME_WIDTH),
        .NUM_FRAMES      (NUM_FRAMES),
        .WORD_WIDTH      (WORD_WIDTH),
        .WORDS_PER_FRAME (WORDS_PER_FRAME),
        .FIDX_W          (FIDX_W),
        .WSEL_W          (RD_ADDR_WIDTH)
    ) u_store (
        .i_clk    (axi_clk),
        .i_rst_n  (axi_resetn),
        .i_we     (w_we),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (frame_in),
        .i_re     (rd_en),
        .i_rzero  (w_rd_zero),
        .i_rframe (w_phys_frame),
        .i_rword  (w_word_idx),
        .o_rdata  (rd_data)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign wrapped     = r_wrapped;
    assign frame_count = r_frame_count;
    assign rd_valid    = r_rd_valid;

endmodule
